// File: rtl/fifo_sync_param.sv
// Synchronous circular-buffer FIFO with any depth >= 2, registered or first-word-fall-through
// read data, occupancy/free counts, programmable almost flags, flush and sticky error flags.
module fifo_sync_param #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         wr_ready,
    output logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   spots,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_fire, wr_fire;

    // Status is derived straight from the registered count
    always_comb begin
        wr_ready     = (count_q != CW'(DEPTH));
        rd_ready     = (count_q != '0);
        count        = count_q;
        spots        = CW'(DEPTH) - count_q;
        almost_full  = (count_q >= CW'(AF_THRESH));
        almost_empty = (count_q <= CW'(AE_THRESH));
        overflow     = ovf_q;
        underflow    = unf_q;
        // A write into a full FIFO still goes through when a read frees a slot this cycle
        rd_fire      = rd_en & rd_ready & ~flush;
        wr_fire      = wr_en & (wr_ready | rd_fire) & ~flush;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (rd_fire) begin
                head_d = (head_q == LAST) ? '0 : head_q + PW'(1);
            end
            if (wr_fire) begin
                tail_d = (tail_q == LAST) ? '0 : tail_q + PW'(1);
            end
            count_d = count_q + CW'(wr_fire) - CW'(rd_fire);
            if (wr_en && !wr_fire) begin
                ovf_d = 1'b1;
            end
            if (rd_en && !rd_ready) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is never read while count is 0, so it needs no reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[tail_q] <= wr_data;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] rd_data_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_data_q <= '0;
                end else if (rd_fire) begin
                    rd_data_q <= mem_q[head_q];
                end
            end
            assign rd_data = rd_data_q;
        end else begin : g_fwft_read
            assign rd_data = rd_ready ? mem_q[head_q] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: directed scenarios on three configurations plus
// randomized traffic compared against a queue-based reference model.
module tb_fifo_sync_param;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // a_: DEPTH=5 registered read; b_: DEPTH=4 FWFT; c_: DEPTH=8 AF=6 AE=2
    logic       a_flush, a_wr, a_rd, a_wrdy, a_rrdy, a_af, a_ae, a_ov, a_un;
    logic [7:0] a_wdata, a_rdata;
    logic [2:0] a_cnt, a_spots;
    logic       b_flush, b_wr, b_rd, b_wrdy, b_rrdy, b_af, b_ae, b_ov, b_un;
    logic [7:0] b_wdata, b_rdata;
    logic [2:0] b_cnt, b_spots;
    logic       c_flush, c_wr, c_rd, c_wrdy, c_rrdy, c_af, c_ae, c_ov, c_un;
    logic [7:0] c_wdata, c_rdata;
    logic [3:0] c_cnt, c_spots;

    fifo_sync_param #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush), .wr_en(a_wr), .wr_data(a_wdata),
        .rd_en(a_rd), .rd_data(a_rdata), .wr_ready(a_wrdy), .rd_ready(a_rrdy),
        .count(a_cnt), .spots(a_spots), .almost_full(a_af), .almost_empty(a_ae),
        .overflow(a_ov), .underflow(a_un));

    fifo_sync_param #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush), .wr_en(b_wr), .wr_data(b_wdata),
        .rd_en(b_rd), .rd_data(b_rdata), .wr_ready(b_wrdy), .rd_ready(b_rrdy),
        .count(b_cnt), .spots(b_spots), .almost_full(b_af), .almost_empty(b_ae),
        .overflow(b_ov), .underflow(b_un));

    fifo_sync_param #(.WIDTH(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_c (
        .clk(clk), .reset(reset), .flush(c_flush), .wr_en(c_wr), .wr_data(c_wdata),
        .rd_en(c_rd), .rd_data(c_rdata), .wr_ready(c_wrdy), .rd_ready(c_rrdy),
        .count(c_cnt), .spots(c_spots), .almost_full(c_af), .almost_empty(c_ae),
        .overflow(c_ov), .underflow(c_un));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks += 9;
        if (a_cnt !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_cnt); end
        if (a_spots !== 3'd5) begin failures++; $display("FAIL reset_spots got=%0d exp=5", a_spots); end
        if (a_wrdy !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", a_wrdy); end
        if (a_rrdy !== 1'b0) begin failures++; $display("FAIL reset_rd_ready got=%b exp=0", a_rrdy); end
        if (a_af !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", a_af); end
        if (a_ae !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%b exp=1", a_ae); end
        if ({a_ov, a_un} !== 2'b00) begin failures++; $display("FAIL reset_errors got=%b exp=00", {a_ov, a_un}); end
        if (a_rdata !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", a_rdata); end
        if (b_rdata !== 8'h00) begin failures++; $display("FAIL reset_fwft_rd_data got=%h exp=00", b_rdata); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 5; i++) begin
            a_wr = 1'b1;
            a_wdata = 8'(17 * (i + 1));
            step();
        end
        checks += 3;
        if (a_wrdy !== 1'b0) begin failures++; $display("FAIL fill_wr_ready got=%b exp=0", a_wrdy); end
        if (a_cnt !== 3'd5) begin failures++; $display("FAIL fill_count got=%0d exp=5", a_cnt); end
        if (a_af !== 1'b1) begin failures++; $display("FAIL fill_almost_full got=%b exp=1", a_af); end
        a_wdata = 8'h66;
        step();
        a_wr = 1'b0;
        checks += 2;
        if (a_ov !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", a_ov); end
        if (a_cnt !== 3'd5) begin failures++; $display("FAIL overflow_count got=%0d exp=5", a_cnt); end
        for (int i = 0; i < 5; i++) begin
            a_rd = 1'b1;
            step();
            exp = 8'(17 * (i + 1));
            checks++;
            if (a_rdata !== exp) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, a_rdata, exp); end
        end
        step();
        a_rd = 1'b0;
        checks += 3;
        if (a_un !== 1'b1) begin failures++; $display("FAIL underflow_set got=%b exp=1", a_un); end
        if (a_rdata !== 8'h55) begin failures++; $display("FAIL underflow_hold got=%h exp=55", a_rdata); end
        if (a_ov !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", a_ov); end
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        checks += 2;
        if ({a_ov, a_un} !== 2'b00) begin failures++; $display("FAIL flush_errors got=%b exp=00", {a_ov, a_un}); end
        if (a_rdata !== 8'h55) begin failures++; $display("FAIL flush_hold_rd got=%h exp=55", a_rdata); end
    endtask

    task automatic test_wrap();
        int wk = 0;
        int rk = 0;
        logic [7:0] exp;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 3; i++) begin
                a_wr = 1'b1;
                a_wdata = 8'(8'hA0 + wk);
                wk++;
                step();
            end
            a_wr = 1'b0;
            for (int i = 0; i < 3; i++) begin
                a_rd = 1'b1;
                step();
                exp = 8'(8'hA0 + rk);
                rk++;
                checks++;
                if (a_rdata !== exp) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", rk - 1, a_rdata, exp); end
            end
            a_rd = 1'b0;
        end
        checks++;
        if (a_cnt !== 3'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", a_cnt); end
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_q[$];
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) begin
            a_wr = 1'b1;
            a_wdata = 8'(i);
            step();
        end
        a_rd = 1'b1;
        a_wdata = 8'hAA;
        step();
        a_wr = 1'b0;
        a_rd = 1'b0;
        checks += 3;
        if (a_cnt !== 3'd5) begin failures++; $display("FAIL full_rw_count got=%0d exp=5", a_cnt); end
        if (a_ov !== 1'b0) begin failures++; $display("FAIL full_rw_overflow got=%b exp=0", a_ov); end
        if (a_rdata !== 8'h01) begin failures++; $display("FAIL full_rw_data got=%h exp=01", a_rdata); end
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'hAA};
        for (int i = 0; i < 5; i++) begin
            a_rd = 1'b1;
            step();
            exp = exp_q[i];
            checks++;
            if (a_rdata !== exp) begin failures++; $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, a_rdata, exp); end
        end
        a_rd = 1'b0;
    endtask

    task automatic test_fwft();
        b_wr = 1'b1;
        b_wdata = 8'h7E;
        step();
        b_wr = 1'b0;
        checks += 2;
        if (b_rrdy !== 1'b1) begin failures++; $display("FAIL fwft_rd_ready got=%b exp=1", b_rrdy); end
        if (b_rdata !== 8'h7E) begin failures++; $display("FAIL fwft_data got=%h exp=7e", b_rdata); end
        b_rd = 1'b1;
        step();
        b_rd = 1'b0;
        checks += 2;
        if (b_rdata !== 8'h00) begin failures++; $display("FAIL fwft_empty_data got=%h exp=00", b_rdata); end
        if (b_rrdy !== 1'b0) begin failures++; $display("FAIL fwft_empty_ready got=%b exp=0", b_rrdy); end
    endtask

    task automatic test_thresholds_flush();
        for (int n = 1; n <= 8; n++) begin
            c_wr = 1'b1;
            c_wdata = 8'(n);
            step();
            checks += 2;
            if (c_ae !== (n <= 2)) begin failures++; $display("FAIL thr_almost_empty n=%0d got=%b exp=%b", n, c_ae, n <= 2); end
            if (c_af !== (n >= 6)) begin failures++; $display("FAIL thr_almost_full n=%0d got=%b exp=%b", n, c_af, n >= 6); end
        end
        step();
        checks++;
        if (c_ov !== 1'b1) begin failures++; $display("FAIL thr_overflow got=%b exp=1", c_ov); end
        c_flush = 1'b1;
        step();
        c_flush = 1'b0;
        c_wr = 1'b0;
        checks += 3;
        if (c_cnt !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", c_cnt); end
        if ({c_ov, c_un} !== 2'b00) begin failures++; $display("FAIL flush_err got=%b exp=00", {c_ov, c_un}); end
        if (c_spots !== 4'd8) begin failures++; $display("FAIL flush_spots got=%0d exp=8", c_spots); end
        step();
        checks++;
        if (c_rrdy !== 1'b0) begin failures++; $display("FAIL flush_write_dropped got=%b exp=0", c_rrdy); end
    endtask

    task automatic test_async_reset();
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_wr = 1'b1;
            a_wdata = 8'(8'hC1 + i);
            step();
        end
        a_wr = 1'b0;
        checks++;
        if (a_cnt !== 3'd3) begin failures++; $display("FAIL areset_pre_count got=%0d exp=3", a_cnt); end
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if (a_cnt !== 3'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", a_cnt); end
        if (a_rrdy !== 1'b0) begin failures++; $display("FAIL areset_rd_ready got=%b exp=0", a_rrdy); end
        if (a_wrdy !== 1'b1) begin failures++; $display("FAIL areset_wr_ready got=%b exp=1", a_wrdy); end
        #2 reset = 1'b1;
        a_wr = 1'b1;
        a_wdata = 8'hD1;
        step();
        a_wr = 1'b0;
        checks++;
        if (a_cnt !== 3'd1) begin failures++; $display("FAIL release_write got=%0d exp=1", a_cnt); end
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        checks += 2;
        if (a_rdata !== 8'hD1) begin failures++; $display("FAIL areset_old_data got=%h exp=d1", a_rdata); end
        if (a_cnt !== 3'd0) begin failures++; $display("FAIL areset_post_count got=%0d exp=0", a_cnt); end
    endtask

    // Reference model: a queue of held words plus sticky error bits
    task automatic test_random_reg();
        logic [7:0] q[$];
        logic [7:0] exp_rd = '0;
        bit known = 0;
        bit ov = 0;
        bit un = 0;
        bit rf, wf;
        for (int cyc = 0; cyc < 400; cyc++) begin
            a_flush = (cyc == 0) || ($urandom_range(0, 39) == 0);
            a_wr = ($urandom_range(0, 9) < 6);
            a_rd = ($urandom_range(0, 9) < 5);
            a_wdata = 8'($urandom);
            if (a_flush) begin
                q.delete();
                ov = 0;
                un = 0;
            end else begin
                rf = a_rd && (q.size() > 0);
                wf = a_wr && ((q.size() < 5) || rf);
                if (a_rd && q.size() == 0) un = 1;
                if (a_wr && !wf) ov = 1;
                if (rf) begin
                    exp_rd = q.pop_front();
                    known = 1;
                end
                if (wf) q.push_back(a_wdata);
            end
            step();
            checks += 7;
            if (a_cnt !== 3'(q.size())) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", cyc, a_cnt, q.size()); end
            if (a_spots !== 3'(5 - q.size())) begin failures++; $display("FAIL rnd_spots c=%0d got=%0d exp=%0d", cyc, a_spots, 5 - q.size()); end
            if ({a_wrdy, a_rrdy} !== {q.size() < 5, q.size() > 0}) begin failures++; $display("FAIL rnd_ready c=%0d got=%b%b", cyc, a_wrdy, a_rrdy); end
            if (a_af !== (q.size() >= 4)) begin failures++; $display("FAIL rnd_af c=%0d got=%b size=%0d", cyc, a_af, q.size()); end
            if (a_ae !== (q.size() <= 1)) begin failures++; $display("FAIL rnd_ae c=%0d got=%b size=%0d", cyc, a_ae, q.size()); end
            if (a_ov !== ov) begin failures++; $display("FAIL rnd_overflow c=%0d got=%b exp=%b", cyc, a_ov, ov); end
            if (a_un !== un) begin failures++; $display("FAIL rnd_underflow c=%0d got=%b exp=%b", cyc, a_un, un); end
            if (known) begin
                checks++;
                if (a_rdata !== exp_rd) begin failures++; $display("FAIL rnd_rd_data c=%0d got=%h exp=%h", cyc, a_rdata, exp_rd); end
            end
        end
        a_flush = 1'b0;
        a_wr = 1'b0;
        a_rd = 1'b0;
    endtask

    task automatic test_random_fwft();
        logic [7:0] q[$];
        logic [7:0] exp_rd;
        bit ov = 0;
        bit un = 0;
        bit rf, wf;
        for (int cyc = 0; cyc < 400; cyc++) begin
            b_flush = (cyc == 0) || ($urandom_range(0, 39) == 0);
            b_wr = ($urandom_range(0, 9) < 5);
            b_rd = ($urandom_range(0, 9) < 5);
            b_wdata = 8'($urandom);
            if (b_flush) begin
                q.delete();
                ov = 0;
                un = 0;
            end else begin
                rf = b_rd && (q.size() > 0);
                wf = b_wr && ((q.size() < 4) || rf);
                if (b_rd && q.size() == 0) un = 1;
                if (b_wr && !wf) ov = 1;
                if (rf) void'(q.pop_front());
                if (wf) q.push_back(b_wdata);
            end
            step();
            exp_rd = (q.size() > 0) ? q[0] : 8'h00;
            checks += 6;
            if (b_cnt !== 3'(q.size())) begin failures++; $display("FAIL fwrnd_count c=%0d got=%0d exp=%0d", cyc, b_cnt, q.size()); end
            if (b_rdata !== exp_rd) begin failures++; $display("FAIL fwrnd_rd_data c=%0d got=%h exp=%h", cyc, b_rdata, exp_rd); end
            if (b_af !== (q.size() >= 3)) begin failures++; $display("FAIL fwrnd_af c=%0d got=%b size=%0d", cyc, b_af, q.size()); end
            if (b_ae !== (q.size() <= 1)) begin failures++; $display("FAIL fwrnd_ae c=%0d got=%b size=%0d", cyc, b_ae, q.size()); end
            if (b_ov !== ov) begin failures++; $display("FAIL fwrnd_overflow c=%0d got=%b exp=%b", cyc, b_ov, ov); end
            if (b_un !== un) begin failures++; $display("FAIL fwrnd_underflow c=%0d got=%b exp=%b", cyc, b_un, un); end
        end
        b_flush = 1'b0;
        b_wr = 1'b0;
        b_rd = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        {a_flush, a_wr, a_rd, a_wdata} = '0;
        {b_flush, b_wr, b_rd, b_wdata} = '0;
        {c_flush, c_wr, c_rd, c_wdata} = '0;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_fwft();
        test_thresholds_flush();
        test_async_reset();
        test_random_reg();
        test_random_fwft();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised successor to the single-mode synchronous FIFO. It provides a circular-buffer FIFO of configurable width and depth (any depth ≥ 2, not only powers of two). The read-data path is selectable between registered and first-word-fall-through (FWFT). It adds occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between producer/consumer pipeline stages in the same clock domain.

## Interface
Parameters:
- WIDTH, 32, data word width in bits (≥ 1)
- DEPTH, 8, number of entries (≥ 2; non-power-of-two legal)
- FWFT, 0, read mode: 0 = registered read data, 1 = first-word-fall-through
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  WIDTH  read data
- wr_ready  out  1  not full
- rd_ready  out  1  not empty
- count  out  CW  entries held
- spots  out  CW  free entries (DEPTH − count)
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- overflow  out  1  sticky: write request dropped
- underflow  out  1  sticky: read request on empty

## Operation
- Storage: DEPTH×WIDTH array. head/tail pointers are $clog2(DEPTH) bits and wrap to 0 after DEPTH−1, not by natural overflow.
- rd_fire = rd_en & rd_ready. wr_fire = wr_en & (wr_ready | rd_fire). A write while full is accepted when a read fires the same cycle.
- Empty + rd_en + wr_en: the read does not fire (no bypass) and the write is stored. count goes 0→1.
- count' = count + wr_fire − rd_fire. spots, wr_ready, rd_ready, almost_full and almost_empty are combinational from the registered count.
- FWFT=0: on rd_fire, rd_data <= mem[head] and head advances. Otherwise rd_data holds.
- FWFT=1: rd_data = mem[head] combinationally when rd_ready, else '0. rd_fire advances head, exposing the next word.
- overflow sets on any cycle with wr_en & !wr_fire. underflow sets on any cycle with rd_en & !rd_ready. Both stay set until flush or reset.
- flush (synchronous, highest priority):
  - head, tail and count go to 0; overflow and underflow clear.
  - rd_en and wr_en that cycle are ignored and set no error.
  - FWFT=0 rd_data holds its value.
- reset (asynchronous, low): clears all state immediately, regardless of clk. Any operation in flight is discarded.

## Timing
- Reset values: count=0, spots=DEPTH, wr_ready=1, rd_ready=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, rd_data='0 (both modes).
- Write→visible latency: rd_ready rises one cycle after the first wr_fire into an empty FIFO.
- FWFT=0 read latency: rd_data is valid the cycle after rd_fire.
- FWFT=1 read latency: zero; data is valid whenever rd_ready=1.
- Flag update: all status outputs reflect the post-edge count in the same cycle the count changes. There are no extra pipeline stages.
- Simultaneous rd_fire & wr_fire: count is unchanged, and both pointers advance and wrap independently.
- Throughput: one write and one read per cycle sustained, including at full and at empty-after-first-write.
- Release from reset: a write is accepted on the first rising edge with reset high.

## Test plan
- Fill/drain, DEPTH=5, WIDTH=8, FWFT=0:
  - Write 0x11..0x55 → wr_ready=0 and count=5 after the 5th edge.
  - A 6th write sets overflow=1 and count stays 5.
  - 5 reads → rd_data 0x11..0x55, each one cycle after its rd_fire.
  - A 6th read sets underflow=1.
- Wrap-around, DEPTH=5:
  - Loop 3 writes then 3 reads, 4 times → all 12 words return in order.
  - Pointers wrap 4→0 with no data corruption.
- Full with simultaneous read+write:
  - At count=5, assert rd_en and wr_en with 0xAA → both fire, count stays 5, overflow stays 0.
  - 0xAA is the last word out.
- FWFT=1, DEPTH=4:
  - Write 0x7E → next cycle rd_ready=1 and rd_data=0x7E with no rd_en.
  - rd_en → rd_data='0 and rd_ready=0 the following cycle.
- Thresholds and flush, DEPTH=8, AF_THRESH=6, AE_THRESH=2:
  - almost_empty drops when count goes 2→3; almost_full rises when count goes 5→6.
  - flush with wr_en=1 → count=0, overflow/underflow=0, and the write is not stored.
- Async reset mid-operation:
  - Drive reset low between clock edges with count=3 → count=0, rd_ready=0 and wr_ready=1 before the next edge.
  - Prior contents are never read back.
